// File: rtl/lateral_distance_requester_pkg.sv
// rtl/lateral_distance_requester_pkg.sv - shared state encoding, Q5.11 constants and defaults
package lateral_distance_requester_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LAUNCH = 4'b0010,
        ST_WAIT   = 4'b0100,
        ST_RESP   = 4'b1000
    } ldr_state_e;

    localparam int unsigned Q_FRAC              = 11;
    localparam logic [15:0] Q_ONE               = 16'h0800;
    localparam int unsigned LDR_DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/lateral_distance_requester_if.sv
// rtl/lateral_distance_requester_if.sv - request, calculator and result signal bundle
interface lateral_distance_requester_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_x;
    logic [15:0]      req_v;
    logic             calc_start;
    logic [15:0]      calc_x;
    logic [15:0]      calc_v;
    logic [15:0]      calc_distance;
    logic             calc_done;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_distance;
    logic             res_timeout;
    logic [CNT_W-1:0] cnt_done;
    logic [CNT_W-1:0] cnt_timeout;

    // master: upstream requester, calculator and downstream consumer side
    modport master (
        output req_valid, req_x, req_v, calc_distance, calc_done, res_ready,
        input  req_ready, calc_start, calc_x, calc_v, res_valid, res_distance,
               res_timeout, cnt_done, cnt_timeout
    );

    modport slave (
        input  req_valid, req_x, req_v, calc_distance, calc_done, res_ready,
        output req_ready, calc_start, calc_x, calc_v, res_valid, res_distance,
               res_timeout, cnt_done, cnt_timeout
    );
endinterface

// File: rtl/lateral_distance_requester_sat_counter.sv
// rtl/lateral_distance_requester_sat_counter.sv - saturating up-counter (sat_counter)
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/lateral_distance_requester.sv
// rtl/lateral_distance_requester.sv - launches one distance calculation per request and holds the result
// Optional WAIT watchdog compiled in with LDR_TIMEOUT_EN.
module lateral_distance_requester
    import lateral_distance_requester_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LDR_DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    lateral_distance_requester_if.slave  bus
);
    ldr_state_e  state_q;
    logic        calc_start_q;
    logic [15:0] op_x_q;
    logic [15:0] op_v_q;
    logic [15:0] res_dist_q;
    logic        res_valid_q;
    logic        res_to;
    logic        resp_xfer;

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

`ifdef LDR_TIMEOUT_EN
    logic       res_timeout_q;
    logic [7:0] wd_q;
    assign res_to = res_timeout_q;
`else
    assign res_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            calc_start_q  <= 1'b0;
            op_x_q        <= '0;
            op_v_q        <= '0;
            res_dist_q    <= '0;
            res_valid_q   <= 1'b0;
`ifdef LDR_TIMEOUT_EN
            res_timeout_q <= 1'b0;
            wd_q          <= '0;
`endif
        end else begin
            case (state_q)
                // A done still asserted here belongs to a finished or abandoned run.
                ST_IDLE: begin
                    if (bus.req_valid && !bus.calc_done) begin
                        op_x_q       <= bus.req_x;
                        op_v_q       <= bus.req_v;
                        calc_start_q <= 1'b1;
                        state_q      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    calc_start_q <= 1'b0;
                    state_q      <= ST_WAIT;
`ifdef LDR_TIMEOUT_EN
                    wd_q         <= '0;
`endif
                end
                ST_WAIT: begin
                    if (bus.calc_done) begin
                        res_dist_q    <= bus.calc_distance;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
`ifdef LDR_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
                    end else if (wd_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        res_dist_q    <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        wd_q          <= wd_q + 8'd1;
`endif
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    calc_start_q <= 1'b0;
                    res_valid_q  <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE) && !bus.calc_done;
    assign bus.calc_start   = calc_start_q;
    assign bus.calc_x       = op_x_q;
    assign bus.calc_v       = op_v_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_distance = res_dist_q;
    assign bus.res_timeout  = res_to;

    assign resp_xfer = (state_q == ST_RESP) && bus.res_ready;

    sat_counter #(.W(CNT_W)) u_cnt_done (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (resp_xfer && !res_to),
        .cnt_o (bus.cnt_done)
    );

    sat_counter #(.W(CNT_W)) u_cnt_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (resp_xfer && res_to),
        .cnt_o (bus.cnt_timeout)
    );
endmodule

// File: tb/tb_lateral_distance_requester.sv
// tb/tb_lateral_distance_requester.sv - scoreboard bench for lateral_distance_requester
module tb_lateral_distance_requester;
    import lateral_distance_requester_pkg::*;

`ifdef LDR_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = LDR_DEFAULT_TIMEOUT;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lateral_distance_requester_if #(.CNT_W(8)) bus();

    lateral_distance_requester #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_done = 0;
    int          exp_to   = 0;
    logic [16:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop on every result handshake.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                check_eq("res_distance", 32'(bus.res_distance), 32'(e[15:0]));
                check_eq("res_timeout", 32'(bus.res_timeout), 32'(e[16]));
                if (e[16]) begin
                    if (exp_to < 255) exp_to++;
                end else begin
                    if (exp_done < 255) exp_done++;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_req(input logic [15:0] x, input logic [15:0] v, input logic [15:0] d,
                           input int done_len, input int ready_dly, input int pre);
        int c;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_x     = x;
        bus.req_v     = v;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_x     = ~x;
        bus.req_v     = ~v;
        check_eq("calc_start_hi", 32'(bus.calc_start), 32'd1);
        check_eq("calc_x", 32'(bus.calc_x), 32'(x));
        check_eq("calc_v", 32'(bus.calc_v), 32'(v));
        sb_q.push_back({1'b0, d});
        @(posedge clk); #1;
        check_eq("calc_start_lo", 32'(bus.calc_start), 32'd0);
        repeat (pre) begin
            @(posedge clk); #1;
        end
        check_eq("no_early_valid", 32'(bus.res_valid), 32'd0);
        bus.calc_done     = 1'b1;
        bus.calc_distance = d;
        @(posedge clk); #1;
        check_eq("done_to_valid", 32'(bus.res_valid), 32'd1);
        check_eq("operands_held", 32'(bus.calc_x), 32'(x));
        bus.calc_distance = ~d;
        c = 1;
        for (int k = 0; k <= ready_dly; k++) begin
            bus.calc_done = (c < done_len);
            bus.res_ready = (k >= ready_dly);
            bus.req_valid = (k < ready_dly);
            check_eq("resp_valid", 32'(bus.res_valid), 32'd1);
            check_eq("resp_distance", 32'(bus.res_distance), 32'(d));
            check_eq("resp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            c++;
        end
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b0;
        check_eq("res_valid_drop", 32'(bus.res_valid), 32'd0);
        check_eq("stall_not_accepted", 32'(bus.calc_start), 32'd0);
        while (c < done_len) begin
            bus.calc_done = 1'b1;
            bus.req_valid = 1'b1;
            #1;
            check_eq("stale_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            check_eq("stale_not_accepted", 32'(bus.calc_start), 32'd0);
            check_eq("stale_no_valid", 32'(bus.res_valid), 32'd0);
            c++;
        end
        bus.calc_done = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check_eq("no_recapture", 32'(bus.res_distance), 32'(d));
        check_eq("ready_after", 32'(bus.req_ready), 32'd1);
        check_eq("cnt_done", 32'(bus.cnt_done), 32'(exp_done));
    endtask

`ifdef LDR_TIMEOUT_EN
    task automatic run_timeout(input logic [15:0] x, input logic [15:0] v);
        int n;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_x     = x;
        bus.req_v     = v;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        sb_q.push_back({1'b1, 16'h0000});
        @(posedge clk); #1;
        n = 0;
        while (!bus.res_valid && n < TO + 5) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("to_latency", 32'(n), 32'(TO));
        check_eq("to_flag", 32'(bus.res_timeout), 32'd1);
        check_eq("to_distance", 32'(bus.res_distance), 32'd0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check_eq("cnt_timeout", 32'(bus.cnt_timeout), 32'(exp_to));
        bus.calc_done     = 1'b1;
        bus.calc_distance = 16'h5555;
        #1;
        check_eq("late_done_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.calc_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("late_done_no_valid", 32'(bus.res_valid), 32'd0);
            check_eq("late_done_distance", 32'(bus.res_distance), 32'd0);
        end
        check_eq("late_cnt_timeout", 32'(bus.cnt_timeout), 32'(exp_to));
        check_eq("late_cnt_done", 32'(bus.cnt_done), 32'(exp_done));
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_x         = '0;
        bus.req_v         = '0;
        bus.calc_done     = 1'b0;
        bus.calc_distance = '0;
        bus.res_ready     = 1'b0;
        rst_n             = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_calc_start", 32'(bus.calc_start), 32'd0);
        check_eq("rst_calc_x", 32'(bus.calc_x), 32'd0);
        check_eq("rst_calc_v", 32'(bus.calc_v), 32'd0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_res_distance", 32'(bus.res_distance), 32'd0);
        check_eq("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
        check_eq("rst_cnt_done", 32'(bus.cnt_done), 32'd0);
        check_eq("rst_cnt_timeout", 32'(bus.cnt_timeout), 32'd0);
        bus.calc_done = 1'b1;
        #1;
        check_eq("rst_ready_with_done", 32'(bus.req_ready), 32'd0);
        bus.calc_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req(Q_ONE, 16'h1000, 16'h0B17, 2, 0, 0);
        check_eq("cnt_done_first", 32'(bus.cnt_done), 32'd1);
        run_req(16'hF800, 16'h7FFF, 16'h8001, 1, 5, 1);
        run_req(16'h1234, 16'hABCD, 16'h4321, 6, 0, 0);
        run_req(16'h0000, 16'hFFFF, 16'hFFFF, 3, 2, 2);
        for (int i = 0; i < 6; i++) begin
            run_req(16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

`ifdef LDR_TIMEOUT_EN
        run_timeout(16'h0100, 16'h0200);
        run_req(16'h0300, 16'h0400, 16'h2468, 1, 0, TO - 1);
        check_eq("coincide_no_timeout", 32'(bus.cnt_timeout), 32'(exp_to));
        run_timeout(16'hFFFF, 16'h8000);
`endif

        // Reset while the calculator is busy, then a stale done after release.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_x     = 16'h0ABC;
        bus.req_v     = 16'h0DEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_done = 0;
        exp_to   = 0;
        check_eq("midrst_calc_x", 32'(bus.calc_x), 32'd0);
        check_eq("midrst_calc_v", 32'(bus.calc_v), 32'd0);
        check_eq("midrst_calc_start", 32'(bus.calc_start), 32'd0);
        check_eq("midrst_res_distance", 32'(bus.res_distance), 32'd0);
        check_eq("midrst_cnt_done", 32'(bus.cnt_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.calc_done     = 1'b1;
        bus.calc_distance = 16'h7777;
        bus.req_valid     = 1'b1;
        #1;
        check_eq("postrst_stale_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.calc_done = 1'b0;
        bus.req_valid = 1'b0;
        check_eq("postrst_not_accepted", 32'(bus.calc_start), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("postrst_no_valid", 32'(bus.res_valid), 32'd0);
            check_eq("postrst_distance", 32'(bus.res_distance), 32'd0);
            check_eq("postrst_cnt_done", 32'(bus.cnt_done), 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            run_req(16'($urandom), 16'($urandom), 16'($urandom), 1, 0, 0);
        end
        check_eq("cnt_done_saturated", 32'(bus.cnt_done), 32'd255);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lateral_distance_requester.md
LATERAL_DISTANCE_REQUESTER -- requirements
Module: lateral_distance_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32, maximum clk cycles spent in WAIT before abort (range 2..255).
REQ-002 Parameter CNT_W, default 8, width of the completion and timeout statistics counters.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  upstream offers an (x, v) pair.
REQ-006 req_x  in  16  Q5.11 lateral offset x.
REQ-007 req_v  in  16  Q5.11 velocity v.
REQ-008 req_ready  out  1  high only in IDLE; the request is accepted on req_valid&&req_ready.
REQ-009 calc_start  out  1  start strobe to the distance calculator.
REQ-010 calc_x, calc_v  out  16 each  operands driven to the calculator.
REQ-011 calc_distance  in  16  Q5.11 result from the calculator.
REQ-012 calc_done  in  1  calculator completion flag; may stay high for 1..N cycles.
REQ-013 res_valid  out  1  a result is held for downstream.
REQ-014 res_ready  in  1  downstream accepts; the transfer occurs on res_valid&&res_ready.
REQ-015 res_distance  out  16  captured distance, or 16'h0000 on timeout.
REQ-016 res_timeout  out  1  qualifies res_distance as aborted; valid only with res_valid.
REQ-017 cnt_done, cnt_timeout  out  CNT_W each  saturating counts of normal completions and timeouts.

Function
REQ-018 The FSM SHALL have four states: IDLE, LAUNCH, WAIT and RESP (one-hot encoded).
REQ-019 IDLE: when req_valid is high, latch req_x/req_v into operand registers and go to LAUNCH.
REQ-020 IDLE: if calc_done is still high, hold req_ready low and stay in IDLE so that a stale done is never counted.
REQ-021 LAUNCH: drive calc_start high for exactly one cycle, then go to WAIT; the falling edge of calc_start is the calculator's trigger.
REQ-022 calc_x/calc_v SHALL hold the latched operands from LAUNCH until the next accepted request; they are never changed while in WAIT.
REQ-023 WAIT: on the first cycle with calc_done high, capture calc_distance into res_distance, clear res_timeout and go to RESP.
REQ-024 Any further calc_done cycles from the same run SHALL be ignored.
REQ-025 The latency from calc_done to res_valid SHALL be exactly 1 cycle.
REQ-026 RESP: res_valid is high; on res_valid&&res_ready, go to IDLE and increment cnt_done or cnt_timeout.
REQ-027 Both statistics counters SHALL saturate at all-ones and never wrap.
REQ-028 calc_done arriving in IDLE, LAUNCH or RESP SHALL have no effect on res_distance.
REQ-029 Arithmetic: this block SHALL pass operands and results through unmodified, with no rounding or sign change.

Reset
REQ-030 While rst_n is low, the FSM is in IDLE, all outputs are 0 (including calc_x/calc_v, res_distance and the counters), and req_ready is derived from IDLE and !calc_done.
REQ-031 Reset asserted mid-operation SHALL abandon the run immediately; a calc_done arriving after release SHALL be treated as stale per REQ-020.

Configuration
REQ-032 Macro LDR_TIMEOUT_EN SHALL compile the WAIT watchdog in or out.
REQ-033 Defined: a counter is cleared on entry to WAIT and increments each WAIT cycle; if it reaches TIMEOUT_CYCLES without calc_done, go to RESP with res_distance=0 and res_timeout=1.
REQ-034 If calc_done and expiry coincide, calc_done SHALL win.
REQ-035 Not defined: WAIT waits indefinitely, res_timeout is tied to 0, cnt_timeout is tied to 0, and no watchdog counter exists.

Structure
REQ-036 A shared package SHALL hold the FSM state typedef, the Q5.11 constants (Q_FRAC=11, Q_ONE=16'h0800) and the default TIMEOUT_CYCLES.
REQ-037 A single sub-module, sat_counter (parameterised width, inc input, saturating), SHALL be instantiated for both statistics counters; everything else is flat.

Verification
REQ-038 Scenario: x=16'h0800, v=16'h1000 in IDLE; calc_start pulses 1 cycle; calc_done held 2 cycles with calc_distance=16'h0B17 -> res_valid the next cycle, res_distance=16'h0B17, cnt_done=1.
REQ-039 Scenario: res_ready held low 5 cycles in RESP -> res_distance stable and req_ready=0 throughout; a new req_valid is not accepted until the handshake completes.
REQ-040 Scenario: LDR_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no calc_done -> res_valid with res_timeout=1, res_distance=0, cnt_timeout=1; a later calc_done pulse is ignored.
REQ-041 Scenario: calc_done still high when returning to IDLE -> req_ready stays 0 until calc_done falls, and no second capture occurs.
REQ-042 Scenario: rst_n dropped in WAIT, then calc_done pulses after release -> outputs stay 0, no res_valid, counters stay 0.
REQ-043 Scenario: 300 back-to-back requests with CNT_W=8 -> cnt_done saturates at 255.
